// File: rtl/nmea_wind_tx.sv
// nmea_wind_tx
//   Converts an 8-bit wind speed sample into the NMEA 0183 sentence
//   "$WIMWV,000,R,ddd,N,A*hh" followed by CR LF. The sentence is sent on a
//   UART line (8N1, LSB first, idle high).
//
//   The speed is converted to three decimal digits by repeated subtraction.
//   The checksum is folded in as each character is loaded for transmission.
//
// Parameters
//   CLK_FREQ     system clock frequency in Hz
//   BAUD         serial bit rate; CLK_FREQ/BAUD clocks per bit
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   speed_in     wind speed 0..255, sampled when speed_valid is high in idle
//   speed_valid  one-cycle qualifier for speed_in
//   tx           serial output
//   busy         high while a sentence is being converted or sent
//   overrun      sticky: a sample arrived while busy; cleared by next capture
module nmea_wind_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 4800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] speed_in,
  input  logic       speed_valid,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_SEND    = 2'd2
  } state_t;

  // The character index runs from 0 to 24.
  // The bit index within a character selects the phase:
  //   0      start bit
  //   1..8   data bits, LSB first
  //   9      stop bit
  state_t          state_q, state_d;
  logic [7:0]      rem_q, rem_d;      // remainder of conversion; units at end
  logic [1:0]      hund_q, hund_d;
  logic [3:0]      tens_q, tens_d;
  logic [7:0]      csum_q, csum_d;
  logic [4:0]      idx_q, idx_d;
  logic [3:0]      bit_q, bit_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [7:0]      char_q, char_d;    // character currently on the line
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      next_char_s;

  // Fold one character into the running XOR checksum.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] ch);
    return acc ^ ch;
  endfunction

  // Convert a decimal digit to ASCII.
  function automatic logic [7:0] dec_ascii(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  // Convert a nibble to an uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] r;
    if (n < 4'd10) begin
      r = 8'h30 + {4'h0, n};
    end else begin
      r = 8'h37 + {4'h0, n};
    end
    return r;
  endfunction

  // Return sentence character idx, built from the digits and the checksum.
  function automatic logic [7:0] sentence_char(
    input logic [4:0] idx,
    input logic [1:0] hund,
    input logic [3:0] tens,
    input logic [3:0] units,
    input logic [7:0] csum
  );
    logic [7:0] c;
    case (idx)
      5'd0:    c = 8'h24;                      // '$'
      5'd1:    c = 8'h57;                      // 'W'
      5'd2:    c = 8'h49;                      // 'I'
      5'd3:    c = 8'h4D;                      // 'M'
      5'd4:    c = 8'h57;                      // 'W'
      5'd5:    c = 8'h56;                      // 'V'
      5'd6:    c = 8'h2C;                      // ','
      5'd7:    c = 8'h30;                      // wind angle "000"
      5'd8:    c = 8'h30;
      5'd9:    c = 8'h30;
      5'd10:   c = 8'h2C;
      5'd11:   c = 8'h52;                      // 'R'
      5'd12:   c = 8'h2C;
      5'd13:   c = dec_ascii({2'b00, hund});
      5'd14:   c = dec_ascii(tens);
      5'd15:   c = dec_ascii(units);
      5'd16:   c = 8'h2C;
      5'd17:   c = 8'h4E;                      // 'N'
      5'd18:   c = 8'h2C;
      5'd19:   c = 8'h41;                      // 'A'
      5'd20:   c = 8'h2A;                      // '*'
      5'd21:   c = hex_ascii(csum[7:4]);
      5'd22:   c = hex_ascii(csum[3:0]);
      5'd23:   c = 8'h0D;
      5'd24:   c = 8'h0A;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  // Look ahead to the character that follows the one now on the line.
  always_comb begin
    next_char_s = sentence_char(idx_q + 5'd1, hund_q, tens_q, rem_q[3:0], csum_q);
  end

  // Next-state logic: capture, decimal conversion, and the serialiser.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    hund_d    = hund_q;
    tens_d    = tens_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    bit_d     = bit_q;
    baud_d    = baud_q;
    char_d    = char_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (speed_valid) begin
          rem_d     = speed_in;
          hund_d    = 2'd0;
          tens_d    = 4'd0;
          csum_d    = 8'd0;
          idx_d     = 5'd0;
          bit_d     = 4'd0;
          baud_d    = '0;
          busy_d    = 1'b1;
          overrun_d = 1'b0;
          state_d   = S_CONVERT;
        end else begin
          state_d   = S_IDLE;
        end
      end

      S_CONVERT: begin
        if (speed_valid) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        // Subtract one hundred or one ten per cycle. The last cycle
        // launches the start bit of '$' directly.
        if (rem_q >= 8'd100) begin
          rem_d  = rem_q - 8'd100;
          hund_d = hund_q + 2'd1;
        end else if (rem_q >= 8'd10) begin
          rem_d  = rem_q - 8'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          char_d  = sentence_char(5'd0, hund_q, tens_q, rem_q[3:0], csum_q);
          idx_d   = 5'd0;
          bit_d   = 4'd0;
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (speed_valid) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            if (idx_q == 5'd24) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
              idx_d   = 5'd0;
              bit_d   = 4'd0;
            end else begin
              // Load the next character and start its start bit with no gap.
              // Characters 1..19 are the ones between '$' and '*'.
              idx_d  = idx_q + 5'd1;
              char_d = next_char_s;
              bit_d  = 4'd0;
              tx_d   = 1'b0;
              if (idx_q < 5'd19) begin
                csum_d = csum_fold(csum_q, next_char_s);
              end else begin
                csum_d = csum_q;
              end
            end
          end else begin
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd8) begin
              tx_d = 1'b1;
            end else begin
              tx_d = char_q[bit_q[2:0]];
            end
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces an idle, quiet line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rem_q     <= 8'd0;
      hund_q    <= 2'd0;
      tens_q    <= 4'd0;
      csum_q    <= 8'd0;
      idx_q     <= 5'd0;
      bit_q     <= 4'd0;
      baud_q    <= '0;
      char_q    <= 8'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      csum_q    <= csum_d;
      idx_q     <= idx_d;
      bit_q     <= bit_d;
      baud_q    <= baud_d;
      char_q    <= char_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_nmea_wind_tx.sv
// tb_nmea_wind_tx
//   Directed bench for nmea_wind_tx with CLK_FREQ=1000 and BAUD=100, which
//   gives 10 clocks per bit.
//
//   Every frame is recorded one sample per clock at the falling edge. Each
//   10-cycle bit window must be constant. Bytes are decoded from those
//   windows and compared with hand-computed sentences.
module tb_nmea_wind_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] speed_in;
  logic       speed_valid;
  logic       tx;
  logic       busy;
  logic       overrun;

  int checks_total  = 0;
  int checks_passed = 0;

  logic       line_bits [0:2499];
  logic [7:0] rx_bytes  [0:24];

  nmea_wind_tx #(
    .CLK_FREQ (1000),
    .BAUD     (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .speed_in    (speed_in),
    .speed_valid (speed_valid),
    .tx          (tx),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Pulse speed_valid for one rising edge, then expect busy to be high.
  // speed_in is then scrambled, so a late read of it would corrupt the frame.
  task automatic pulse_valid(input logic [7:0] spd, input bit wait_neg, input string name);
    if (wait_neg) @(negedge clk);
    speed_in    = spd;
    speed_valid = 1'b1;
    @(negedge clk);
    speed_valid = 1'b0;
    speed_in    = ~spd;
    checks_total++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_capture got=%b want=1", name, busy);
    else checks_passed++;
  endtask

  // Record one frame and check its timing, framing and characters.
  // Optionally inject a speed_valid pulse at frame sample inj_sample.
  task automatic receive_frame(input string name, input string exp_text,
                               input int inj_sample, input logic [7:0] inj_spd);
    int lat;
    bit found;
    bit busy_ok;
    bit timing_ok;
    bit framing_ok;
    int base;
    logic [7:0] exp_b;
    lat = 0; found = 1'b0; busy_ok = 1'b1;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (tx === 1'b0) begin found = 1'b1; lat = i; end
    end
    checks_total++;
    if (!found || lat > 12) $display("FAIL %s start_latency got=%0d want<=12 (found=%0d)", name, lat, found);
    else checks_passed++;
    if (!found) return;

    line_bits[0] = tx;
    for (int s = 1; s < 2500; s++) begin
      @(negedge clk);
      if (s == inj_sample) begin
        speed_in = inj_spd; speed_valid = 1'b1;
      end else if (s == inj_sample + 1) begin
        speed_valid = 1'b0; speed_in = 8'h00;
      end
      line_bits[s] = tx;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    checks_total++;
    if (!busy_ok) $display("FAIL %s busy_during_frame got=dropped want=held_high", name);
    else checks_passed++;

    @(negedge clk);
    checks_total++;
    if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL %s frame_end got tx=%b busy=%b want tx=1 busy=0", name, tx, busy);
    else checks_passed++;

    timing_ok = 1'b1; framing_ok = 1'b1;
    for (int c = 0; c < 25; c++) begin
      for (int b = 0; b < 10; b++) begin
        base = (c * 10 + b) * 10;
        for (int k = 1; k < 10; k++) begin
          if (line_bits[base + k] !== line_bits[base]) timing_ok = 1'b0;
        end
        if (b == 0 && line_bits[base] !== 1'b0) framing_ok = 1'b0;
        if (b == 9 && line_bits[base] !== 1'b1) framing_ok = 1'b0;
        if (b >= 1 && b <= 8) rx_bytes[c][b - 1] = line_bits[base];
      end
    end
    checks_total++;
    if (!timing_ok) $display("FAIL %s bit_timing got=uneven want=10_cycle_bits", name);
    else checks_passed++;
    checks_total++;
    if (!framing_ok) $display("FAIL %s framing got=bad_start_or_stop want=0_start_1_stop", name);
    else checks_passed++;

    for (int c = 0; c < 25; c++) begin
      if (c < 23) exp_b = exp_text[c];
      else if (c == 23) exp_b = 8'h0D;
      else exp_b = 8'h0A;
      checks_total++;
      if (rx_bytes[c] !== exp_b)
        $display("FAIL %s char[%0d] got=%02h want=%02h", name, c, rx_bytes[c], exp_b);
      else checks_passed++;
    end
  endtask

  // Check the reset outputs, then release reset and send a sample at once.
  task automatic test_reset;
    reset = 1'b1; speed_valid = 1'b0; speed_in = 8'h00;
    repeat (3) @(negedge clk);
    checks_total++;
    if (tx !== 1'b1) $display("FAIL reset_tx got=%b want=1", tx); else checks_passed++;
    checks_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else checks_passed++;
    checks_total++;
    if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b want=0", overrun); else checks_passed++;
    reset = 1'b0;
    pulse_valid(8'd0, 1'b0, "first_after_reset");
    receive_frame("speed0", "$WIMWV,000,R,000,N,A*23", -1, 8'h00);
    checks_total++;
    if (overrun !== 1'b0) $display("FAIL speed0_overrun got=%b want=0", overrun); else checks_passed++;
  endtask

  // The line stays idle high between frames.
  task automatic test_idle_gap;
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    checks_total++;
    if (!ok) $display("FAIL idle_gap got=activity want=tx_high_busy_low"); else checks_passed++;
  endtask

  // Send several speeds; 199 takes the longest decimal conversion.
  task automatic test_values;
    pulse_valid(8'd255, 1'b1, "speed255");
    receive_frame("speed255", "$WIMWV,000,R,255,N,A*21", -1, 8'h00);
    pulse_valid(8'd123, 1'b1, "speed123");
    receive_frame("speed123", "$WIMWV,000,R,123,N,A*23", -1, 8'h00);
    pulse_valid(8'd199, 1'b1, "speed199");
    receive_frame("speed199", "$WIMWV,000,R,199,N,A*22", -1, 8'h00);
  endtask

  // A sample arriving mid-frame is dropped and sets overrun; the next
  // sample accepted in idle clears overrun.
  task automatic test_overrun;
    pulse_valid(8'd10, 1'b1, "ovr_first");
    receive_frame("ovr_first", "$WIMWV,000,R,010,N,A*22", 300, 8'd50);
    checks_total++;
    if (overrun !== 1'b1) $display("FAIL overrun_set got=%b want=1", overrun); else checks_passed++;
    pulse_valid(8'd50, 1'b1, "ovr_next");
    checks_total++;
    if (overrun !== 1'b0) $display("FAIL overrun_clear got=%b want=0", overrun); else checks_passed++;
    receive_frame("ovr_next", "$WIMWV,000,R,050,N,A*26", -1, 8'h00);
  endtask

  // A valid in the very cycle busy falls starts a new frame.
  task automatic test_back_to_back;
    pulse_valid(8'd7, 1'b1, "speed7");
    receive_frame("speed7", "$WIMWV,000,R,007,N,A*24", -1, 8'h00);
    pulse_valid(8'd123, 1'b0, "b2b");
    checks_total++;
    if (overrun !== 1'b0) $display("FAIL b2b_overrun got=%b want=0", overrun); else checks_passed++;
    receive_frame("b2b", "$WIMWV,000,R,123,N,A*23", -1, 8'h00);
  endtask

  // Reset during character 8 aborts the frame; the line stays quiet until
  // a fresh sample arrives, which is then sent complete.
  task automatic test_reset_mid_frame;
    bit ok;
    pulse_valid(8'd99, 1'b1, "abort");
    repeat (850) @(negedge clk);
    reset = 1'b1;
    #1;
    checks_total++;
    if (tx !== 1'b1 || busy !== 1'b0)
      $display("FAIL abort_immediate got tx=%b busy=%b want tx=1 busy=0", tx, busy);
    else checks_passed++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    checks_total++;
    if (!ok) $display("FAIL abort_quiet got=activity want=idle"); else checks_passed++;
    pulse_valid(8'd42, 1'b0, "after_abort");
    receive_frame("after_abort", "$WIMWV,000,R,042,N,A*25", -1, 8'h00);
  endtask

  // Stop the run if it exceeds its time limit.
  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // Run the scenarios in order and print the summary line.
  initial begin
    test_reset();
    test_idle_gap();
    test_values();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/nmea_wind_tx.md
NMEA_WIND_TX -- requirements
Module: nmea_wind_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 4800, serial bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer truncation) clocks per bit.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 speed_in  input  8  wind speed, unsigned binary, 0..255.
REQ-006 speed_valid  input  1  one-cycle qualifier for speed_in (driven by the anemometer measurement block).
REQ-007 tx  output  1  UART serial line, idle high, 8N1, LSB first.
REQ-008 busy  output  1  high while a sentence is being converted or transmitted.
REQ-009 overrun  output  1  sticky flag: a speed_valid arrived while busy.

Function
REQ-010 Sentence sent per accepted sample SHALL be exactly 25 characters: "$WIMWV,000,R,ddd,N,A*hh" followed by CR (0x0D) and LF (0x0A).
REQ-011 ddd SHALL be speed_in in decimal, 3 ASCII digits, zero-padded (e.g. 7 -> "007", 255 -> "255").
REQ-012 hh SHALL be the XOR of all characters strictly between '$' and '*', as two uppercase ASCII hex digits, high nibble first.
REQ-013 States: IDLE, CONVERT, SEND, with SEND sub-phases START, DATA (8 bits), STOP per character.
REQ-014 IDLE: speed_valid=1 SHALL capture speed_in in that cycle and move to CONVERT; busy high from the next cycle.
REQ-015 CONVERT: binary-to-BCD by repeated subtraction, one subtraction of 100 or 10 per cycle, remainder is units; SHALL finish in at most 11 cycles, then enter SEND at character index 0.
REQ-016 Start bit of '$' SHALL begin no later than 12 cycles after the capture cycle.
REQ-017 Each bit (start, 8 data, stop) SHALL hold tx for exactly BAUD_DIV cycles; characters back-to-back, no idle gap between stop bit and next start bit.
REQ-018 Checksum accumulator SHALL clear at capture and XOR each character of indices 1..19 as it is loaded; hex digits SHALL be derived from the final value at indices 21..22.
REQ-019 Character index counter 0..24; after the stop bit of index 24 (LF) ends, SHALL return to IDLE, busy low, tx high.
REQ-020 speed_valid while busy (CONVERT or SEND) SHALL be ignored (no capture, frame unaffected) and SHALL set overrun.
REQ-021 overrun SHALL clear on the next accepted capture in IDLE; speed_valid in the same cycle busy falls (already IDLE) SHALL be accepted normally.
REQ-022 speed_in changes after capture SHALL not affect the sentence in progress.
REQ-023 Total sentence duration SHALL be 250*BAUD_DIV cycles.

Reset
REQ-024 reset=1 SHALL asynchronously force: state IDLE, tx=1, busy=0, overrun=0, all counters and checksum 0.
REQ-025 Reset mid-frame SHALL abort the sentence immediately (tx high during reset); after release no partial frame resumes and the next speed_valid starts a full new sentence.
REQ-026 First speed_valid seen after reset release is accepted on the first rising edge with reset low.

Verification (CLK_FREQ=1000, BAUD=100 -> BAUD_DIV=10)
REQ-027 speed_in=0, one-cycle valid -> decoded tx bytes "$WIMWV,000,R,000,N,A*23" CR LF; busy high for CONVERT + 2500 cycles; overrun=0.
REQ-028 speed_in=255 -> "...R,255,N,A*21" CR LF; speed_in=123 -> "...R,123,N,A*23"; speed_in=7 -> digits "007".
REQ-029 Second valid (speed_in=50) mid-SEND of speed 10 -> frame still carries "010", overrun=1; next valid in IDLE sends its value and clears overrun.
REQ-030 Bit timing check: every tx transition spaced by multiples of exactly 10 cycles within a frame; start bit of '$' within 12 cycles of capture; tx idle high between frames.
REQ-031 Assert reset for 3 cycles during character index 8 -> tx=1, busy=0 immediately; after release no activity until new valid; new valid (speed 42) yields complete correct "042" sentence.
REQ-032 Valid in the exact cycle busy deasserts -> accepted, new sentence starts, overrun unchanged from 0.
